lifo_stream_reader: RTL
=======================

Name: lifo_stream_reader

Overview:
Downstream drain stage for the team's synchronous-read LIFO. It issues read requests to the LIFO and absorbs the LIFO's 1-cycle read latency. Popped words are presented on a valid/ready stream, with a last tag on the word that empties the LIFO. A 3-entry output buffer allows full throughput with no combinational path from src_ready_i to lifo_rdreq_o.

Parameters:
DWIDTH, 8, data width; must equal the LIFO DWIDTH.
AWIDTH, 4, LIFO address width; lifo_usedw_i is AWIDTH+1 bits.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
clk_i  input  1  clock; all logic on rising edge
srst_i  input  1  synchronous active-high reset
enable_i  input  1  1 = drain allowed; 0 = no new rdreq (in-flight words still delivered)
lifo_empty_i  input  1  LIFO empty_o
lifo_usedw_i  input  AWIDTH+1  LIFO usedw_o
lifo_wrreq_i  input  1  upstream write request to the LIFO in this cycle (snooped)
lifo_q_i  input  DWIDTH  LIFO q_o; valid the cycle after rdreq
lifo_rdreq_o  output  1  read request to the LIFO
src_data_o  output  DWIDTH  stream data
src_last_o  output  1  word was popped when lifo_usedw_i == 1
src_valid_o  output  1  stream valid
src_ready_i  input  1  stream ready
rd_cnt_o  output  CNT_WIDTH  count of words accepted on the stream; wraps modulo 2**CNT_WIDTH
busy_o  output  1  pending read or buffer non-empty

Behaviour:
- Reset: lifo_rdreq_o=0, src_valid_o=0, src_last_o=0, src_data_o=0, rd_cnt_o=0, busy_o=0. The pending flag and buffer are cleared. A word in flight during reset is discarded; reset mid-stream drops all buffered words.
- Issue rule (combinational from registers and LIFO flags only): lifo_rdreq_o = enable_i && !lifo_empty_i && !lifo_wrreq_i && (buf_cnt + pending) < 3. Here buf_cnt is the registered buffer occupancy (0..3) and pending is a 1-bit flag.
- lifo_rdreq_o never depends on src_ready_i or src_valid_o.
- Simultaneous upstream write blocks the read that cycle (the LIFO gives wrreq priority). The read retries on the next eligible cycle.
- At each edge where lifo_rdreq_o=1: pending<=1 and pend_last<=(lifo_usedw_i==1). Otherwise pending<=0.
- Capture: when pending=1, {lifo_q_i, pend_last} is written into the buffer at this edge.
- Buffer: 3-entry FIFO in arrival order; head drives src_data_o/src_last_o/src_valid_o.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- Overflow is impossible by the credit rule; an assertion checks buf_cnt never exceeds 3.
- Latency: rdreq at cycle N -> src_valid_o=1 at cycle N+2 when the buffer was empty.
- Throughput: 1 word/cycle sustained while src_ready_i=1, the LIFO is non-empty and there are no upstream writes.
- Stream rules: once src_valid_o=1, src_data_o and src_last_o stay stable until src_valid_o && src_ready_i.
- rd_cnt_o increments by 1 on each accepted word and wraps from all-ones to 0.
- busy_o = pending || (buf_cnt != 0).
- Deasserting enable_i stops rdreq the same cycle. Pending and buffered words still drain.
- Assertions (simulation only): lifo_rdreq_o implies !lifo_empty_i; lifo_rdreq_o implies !lifo_wrreq_i; src_data_o stable while valid && !ready.

Decomposition:
- Package lifo_pkg: localparam RD_BUF_DEPTH = 3; the credit-width constant derived from it.
- The entry type is {last, data}, declared locally because it depends on DWIDTH.
- Sub-module lifo_rd_buf: 3-entry show-ahead FIFO with push/pop, count and head outputs, synchronous reset.
- The top level holds the issue logic, the pending flag/last tag and rd_cnt_o.

Test Plan:
- Reset, then LIFO preloaded with 0x11,0x22,0x33 (top 0x33), ready=1, enable=1 -> stream delivers 0x33, 0x22, 0x11 on consecutive cycles; last=1 only on 0x11; rd_cnt_o=3; busy_o=0 afterwards.
- First-word latency: LIFO holds one word 0xA5, enable rises at cycle N -> rdreq at N, src_valid_o at N+2 with last=1.
- Backpressure: LIFO holds 8 words, ready=0 -> exactly 3 rdreqs issued and then held; data stable. Raising ready -> remaining 5 words follow with no gap; all 8 delivered in LIFO order.
- Write collision: lifo_wrreq_i=1 for 2 cycles mid-drain -> no rdreq in those cycles (assertion quiet); the newly written word is delivered next. No data loss or duplication.
- Reset mid-operation: srst_i pulsed with pending=1 and buf_cnt=2 -> next cycle src_valid_o=0, rd_cnt_o=0, busy_o=0; no stale word appears afterwards.
- Counter wrap with CNT_WIDTH=4: deliver 17 words -> rd_cnt_o reads 1.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared constants and helpers for the LIFO read/drain path.
package lifo_pkg;

    localparam int unsigned RD_BUF_DEPTH = 3;

    // Buffer occupancy spans 0..RD_BUF_DEPTH
    localparam int unsigned RD_CNT_W = $clog2(RD_BUF_DEPTH + 1);

    // Credits in use = occupancy plus one read still in flight from the LIFO
    localparam int unsigned RD_CREDIT_W = $clog2(RD_BUF_DEPTH + 2);

    localparam int unsigned RD_PTR_W = $clog2(RD_BUF_DEPTH);

    function automatic logic [RD_PTR_W-1:0] rd_ptr_inc(input logic [RD_PTR_W-1:0] ptr);
        if (ptr == RD_PTR_W'(RD_BUF_DEPTH - 1)) begin
            return '0;
        end
        return ptr + RD_PTR_W'(1);
    endfunction

endpackage

// File: rtl/lifo_rd_buf.sv
// Small show-ahead FIFO holding words returned by the LIFO until the stream
// consumer takes them. Head is visible combinationally whenever valid_o is set.
module lifo_rd_buf
    import lifo_pkg::*;
#(
    parameter int unsigned Width = 9
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                push_i,
    input  logic [Width-1:0]    push_data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    head_o,
    output logic                valid_o,
    output logic [RD_CNT_W-1:0] count_o
);

    logic [Width-1:0]    mem_q [RD_BUF_DEPTH];
    logic [RD_PTR_W-1:0] wr_ptr_q;
    logic [RD_PTR_W-1:0] rd_ptr_q;
    logic [RD_CNT_W-1:0] count_q;
    logic [RD_CNT_W-1:0] count_d;
    logic                full;
    logic                do_push;
    logic                do_pop;

    assign full    = (count_q == RD_CNT_W'(RD_BUF_DEPTH));
    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    // Writing a full buffer is only legal when the head leaves in the same cycle
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + RD_CNT_W'(1);
            2'b01:   count_d = count_q - RD_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= rd_ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (srst_i)
        push_i |-> (!full || pop_i));

endmodule

// File: rtl/lifo_stream_reader.sv
// Drain stage for the synchronous-read LIFO: issues reads, absorbs the one-cycle
// read latency and presents popped words on a valid/ready stream with a last tag.
module lifo_stream_reader
    import lifo_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned AWIDTH    = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 enable_i,
    input  logic                 lifo_empty_i,
    input  logic [AWIDTH:0]      lifo_usedw_i,
    input  logic                 lifo_wrreq_i,
    input  logic [DWIDTH-1:0]    lifo_q_i,
    output logic                 lifo_rdreq_o,
    output logic [DWIDTH-1:0]    src_data_o,
    output logic                 src_last_o,
    output logic                 src_valid_o,
    input  logic                 src_ready_i,
    output logic [CNT_WIDTH-1:0] rd_cnt_o,
    output logic                 busy_o
);

    typedef struct packed {
        logic              last;
        logic [DWIDTH-1:0] data;
    } rd_entry_t;

    localparam logic [AWIDTH:0] USEDW_ONE = (AWIDTH + 1)'(1);

    logic                   pending_q;
    logic                   pend_last_q;
    logic [CNT_WIDTH-1:0]   rd_cnt_q;
    logic [RD_CNT_W-1:0]    buf_cnt;
    logic [RD_CREDIT_W-1:0] credit_used;
    logic                   credit_ok;
    logic                   accept;
    rd_entry_t              push_entry;
    rd_entry_t              head_entry;

    // Issue decision uses only registered state and LIFO flags, never the stream side
    assign credit_used  = RD_CREDIT_W'(buf_cnt) + RD_CREDIT_W'(pending_q);
    assign credit_ok    = (credit_used < RD_CREDIT_W'(RD_BUF_DEPTH));
    assign lifo_rdreq_o = !srst_i && enable_i && !lifo_empty_i && !lifo_wrreq_i && credit_ok;

    assign accept = src_valid_o && src_ready_i;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pending_q   <= 1'b0;
            pend_last_q <= 1'b0;
            rd_cnt_q    <= '0;
        end else begin
            pending_q <= lifo_rdreq_o;
            if (lifo_rdreq_o) begin
                pend_last_q <= (lifo_usedw_i == USEDW_ONE);
            end
            if (accept) begin
                rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign push_entry.last = pend_last_q;
    assign push_entry.data = lifo_q_i;

    lifo_rd_buf #(
        .Width($bits(rd_entry_t))
    ) u_rd_buf (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .push_i      (pending_q),
        .push_data_i (push_entry),
        .pop_i       (accept),
        .head_o      (head_entry),
        .valid_o     (src_valid_o),
        .count_o     (buf_cnt)
    );

    assign src_data_o = head_entry.data;
    assign src_last_o = head_entry.last;
    assign rd_cnt_o   = rd_cnt_q;
    assign busy_o     = pending_q || (buf_cnt != '0);

    a_rd_not_empty: assert property (@(posedge clk_i) disable iff (srst_i)
        lifo_rdreq_o |-> !lifo_empty_i);

    a_rd_not_wr: assert property (@(posedge clk_i) disable iff (srst_i)
        lifo_rdreq_o |-> !lifo_wrreq_i);

    a_stream_stable: assert property (@(posedge clk_i) disable iff (srst_i)
        (src_valid_o && !src_ready_i) |=>
            (src_valid_o && $stable(src_data_o) && $stable(src_last_o)));

    a_credit_bound: assert property (@(posedge clk_i) disable iff (srst_i)
        credit_used <= RD_CREDIT_W'(RD_BUF_DEPTH));

endmodule
